memory_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage in the 64-bit RISC-V core.
- Registers the execute result and performs the data-memory access for loads and stores.
- Talks to data memory over a variable-latency req/ack handshake.
- Drives one writeback beat per accepted instruction, with sub-word load extraction, sign/zero extension, store byte-lane strobes and alignment checking.

---
 rtl/memory_access_stage_if.sv | 67 ++++++
 rtl/memory_access_stage.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
//
// Purpose:
//   Bundles every bus-level signal of the memory access stage. This covers the
//   execute-side hand-off, the data-memory req/ack channel and the writeback
//   beat. Clock and reset stay outside the interface as plain ports.
//
// Modports:
//   slave  - the memory access stage itself. It receives the execute result
//            and the memory response. It drives ex_ready, the memory request
//            and the writeback beat.
//   master - the surrounding environment: the execute stage, the data memory
//            and the writeback consumer, seen as one party.
//
// Signal summary:
//   ex_valid, ex_ready                execute hand-off (accept = valid & ready)
//   ALUResult[63:0], storeData[63:0]  effective address / ALU value, rs2
//   funct3[2:0], MemRead, MemWrite    access size/sign, load, store
//   RegWrite, rd[4:0]                 register-file write request
//   mem_req, mem_we, mem_addr[63:0]   memory request, held until mem_ack
//   mem_wdata[63:0], mem_wstrb[7:0]   lane-shifted store data and byte enables
//   mem_ack, mem_rdata[63:0]          memory completion and load doubleword
//   wb_valid, wb_data[63:0], wb_rd    one-cycle writeback beat
//   wb_RegWrite, mem_fault            write enable and access fault flag
// -----------------------------------------------------------------------------
interface memory_access_stage_if;

    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ALUResult;
    logic [63:0] storeData;
    logic [2:0]  funct3;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [4:0]  rd;

    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite;
    logic        mem_fault;

    modport slave (
        input  ex_valid, ALUResult, storeData, funct3, MemRead, MemWrite,
               RegWrite, rd, mem_ack, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_data, wb_rd, wb_RegWrite, mem_fault
    );

    modport master (
        output ex_valid, ALUResult, storeData, funct3, MemRead, MemWrite,
               RegWrite, rd, mem_ack, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_data, wb_rd, wb_RegWrite, mem_fault
    );

endinterface

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// Purpose:
//   This is the pipeline stage after execute in the 64-bit RISC-V core.
//
//   - Non-memory instructions pass straight to writeback one cycle after
//     they are accepted.
//   - Loads and stores are checked for legality and alignment when accepted.
//     A legal access is then issued to data memory over a req/ack handshake
//     with variable latency.
//   - On completion the stage produces one writeback beat. For loads the
//     selected lane is sign- or zero-extended.
//   - An illegal access issues no memory request. It produces a single
//     writeback beat flagged with mem_fault.
//
// Ports:
//   clk    - core clock
//   reset  - synchronous, active-high reset; clears every registered output
//            and returns the FSM to IDLE
//   bus    - memory_access_stage_if.slave: execute hand-off, data-memory
//            req/ack channel and writeback beat (see the interface file)
//
// Parameters:
//   TIMEOUT_CYCLES - number of ACCESS cycles without mem_ack after which the
//                    access is aborted with mem_fault. Only meaningful when
//                    MEM_TIMEOUT_EN is defined.
//
// Build options:
//   MEM_TIMEOUT_EN - when defined, an 8-bit counter aborts a memory access
//                    that waits TIMEOUT_CYCLES cycles without an ack. When
//                    undefined, ACCESS waits for mem_ack indefinitely.
// -----------------------------------------------------------------------------
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_access_stage_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Control strobes decoded from the current state and inputs
    logic accept_alu;
    logic accept_fault;
    logic accept_mem;
    logic complete_ack;
    logic abort_timeout;
    logic timeout_hit;

    // Accept-time decode of the incoming instruction
    logic       is_mem_op;
    logic       misaligned;
    logic       access_fault;
    logic [2:0] in_offset;
    logic [7:0] strb_base;

    // Attributes of the in-flight memory access, captured at accept
    logic        held_is_load;
    logic [2:0]  held_funct3;
    logic [63:0] held_addr;
    logic [4:0]  held_rd;
    logic        held_regwrite;

    // Load lane selection and extension
    logic [63:0] rdata_shifted;
    logic [63:0] load_value;

    // Registered outputs
    logic        mem_req_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic [7:0]  mem_wstrb_q;
    logic        wb_valid_q;
    logic [63:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_regwrite_q;
    logic        mem_fault_q;

    assign bus.ex_ready    = (state == IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_RegWrite = wb_regwrite_q;
    assign bus.mem_fault   = mem_fault_q;

    assign is_mem_op = bus.MemRead | bus.MemWrite;
    assign in_offset = bus.ALUResult[2:0];

    // funct3[1:0] encodes the access size for both loads and stores. The
    // unsigned-load variants share the same size bits as the signed ones.
    always_comb begin
        misaligned = 1'b0;
        strb_base  = 8'h01;
        case (bus.funct3[1:0])
            2'b00: begin
                misaligned = 1'b0;
                strb_base  = 8'h01;
            end
            2'b01: begin
                misaligned = bus.ALUResult[0];
                strb_base  = 8'h03;
            end
            2'b10: begin
                misaligned = |bus.ALUResult[1:0];
                strb_base  = 8'h0F;
            end
            default: begin
                misaligned = |bus.ALUResult[2:0];
                strb_base  = 8'hFF;
            end
        endcase
    end

    // Illegal encodings are a load with funct3=111 (no such load) and any
    // store with funct3[2] set (no unsigned stores). A simultaneous
    // read+write request is also rejected, and so is a misaligned address.
    assign access_fault = (bus.MemRead & bus.MemWrite)
                        | (bus.MemRead & (bus.funct3 == 3'b111))
                        | (bus.MemWrite & bus.funct3[2])
                        | misaligned;

    // The memory returns a whole doubleword, so the addressed lane is shifted
    // down to bit 0 first. Extension then keys off the held funct3.
    assign rdata_shifted = bus.mem_rdata >> {held_addr[2:0], 3'b000};

    always_comb begin
        load_value = rdata_shifted;
        case (held_funct3)
            3'b000:  load_value = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_value = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b010:  load_value = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'b011:  load_value = rdata_shifted;
            3'b100:  load_value = {56'd0, rdata_shifted[7:0]};
            3'b101:  load_value = {48'd0, rdata_shifted[15:0]};
            3'b110:  load_value = {32'd0, rdata_shifted[31:0]};
            default: load_value = rdata_shifted;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] timeout_count;

    // The counter restarts whenever a new access is issued. It then counts
    // every ACCESS cycle that passes without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_count <= 8'd0;
        end else if (accept_mem) begin
            timeout_count <= 8'd0;
        end else if ((state == ACCESS) && !bus.mem_ack) begin
            timeout_count <= timeout_count + 8'd1;
        end
    end

    // The limit is hit when this ack-less cycle would bring the counter up
    // to TIMEOUT_CYCLES. With this check the request stays up for exactly
    // TIMEOUT_CYCLES cycles.
    assign timeout_hit = (state == ACCESS)
                       && ((9'({1'b0, timeout_count}) + 9'd1) == 9'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. In IDLE an accepted instruction goes down one of
    // three paths: writeback only, fault beat, or memory access. In ACCESS
    // an ack is checked before the timeout, so an ack on the limit cycle
    // still completes normally.
    always_comb begin
        next_state    = state;
        accept_alu    = 1'b0;
        accept_fault  = 1'b0;
        accept_mem    = 1'b0;
        complete_ack  = 1'b0;
        abort_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (!is_mem_op) begin
                        accept_alu = 1'b1;
                    end else if (access_fault) begin
                        accept_fault = 1'b1;
                    end else begin
                        accept_mem = 1'b1;
                        next_state = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    complete_ack = 1'b1;
                    next_state   = IDLE;
                end else if (timeout_hit) begin
                    abort_timeout = 1'b1;
                    next_state    = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output and datapath registers.
    // - wb_valid and mem_fault default low, so every beat lasts exactly one
    //   cycle.
    // - The other wb_* fields hold their last value between beats.
    // - The memory request fields hold from issue until the ack edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 64'd0;
            mem_wdata_q   <= 64'd0;
            mem_wstrb_q   <= 8'd0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 64'd0;
            wb_rd_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            mem_fault_q   <= 1'b0;
            held_is_load  <= 1'b0;
            held_funct3   <= 3'd0;
            held_addr     <= 64'd0;
            held_rd       <= 5'd0;
            held_regwrite <= 1'b0;
        end else begin
            wb_valid_q  <= 1'b0;
            mem_fault_q <= 1'b0;

            if (accept_alu) begin
                wb_valid_q    <= 1'b1;
                wb_data_q     <= bus.ALUResult;
                wb_rd_q       <= bus.rd;
                wb_regwrite_q <= bus.RegWrite;
            end

            if (accept_fault) begin
                wb_valid_q    <= 1'b1;
                mem_fault_q   <= 1'b1;
                wb_data_q     <= bus.ALUResult;
                wb_rd_q       <= bus.rd;
                wb_regwrite_q <= 1'b0;
            end

            if (accept_mem) begin
                mem_req_q     <= 1'b1;
                mem_we_q      <= bus.MemWrite;
                mem_addr_q    <= {bus.ALUResult[63:3], 3'b000};
                mem_wdata_q   <= bus.MemWrite ? (bus.storeData << {in_offset, 3'b000}) : 64'd0;
                mem_wstrb_q   <= bus.MemWrite ? (strb_base << in_offset) : 8'd0;
                held_is_load  <= bus.MemRead;
                held_funct3   <= bus.funct3;
                held_addr     <= bus.ALUResult;
                held_rd       <= bus.rd;
                held_regwrite <= bus.RegWrite;
            end

            // Store completions report the address on wb_data. Their
            // write enable is forced low, so the value is informational.
            if (complete_ack) begin
                mem_req_q     <= 1'b0;
                wb_valid_q    <= 1'b1;
                wb_rd_q       <= held_rd;
                wb_regwrite_q <= held_is_load & held_regwrite;
                wb_data_q     <= held_is_load ? load_value : held_addr;
            end

            if (abort_timeout) begin
                mem_req_q     <= 1'b0;
                wb_valid_q    <= 1'b1;
                mem_fault_q   <= 1'b1;
                wb_rd_q       <= held_rd;
                wb_regwrite_q <= 1'b0;
                wb_data_q     <= held_addr;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//
// Purpose:
//   Directed testbench for memory_access_stage. It exercises:
//   - ALU pass-through
//   - sub-word loads with sign and zero extension
//   - store lane shifting and strobes
//   - accept-time faults
//   - reset in the middle of an access
//   - the optional access timeout (MEM_TIMEOUT_EN)
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

    logic clk;
    logic reset;

    int compared;
    int mismatched;

    memory_access_stage_if bus ();

    memory_access_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to one time unit past the next rising edge. Inputs are driven
    // and outputs sampled there, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic [63:0] alu,
        input logic [63:0] sdata,
        input logic [2:0]  f3,
        input logic        mread,
        input logic        mwrite,
        input logic        rwrite,
        input logic [4:0]  rdest
    );
        bus.ex_valid  = valid;
        bus.ALUResult = alu;
        bus.storeData = sdata;
        bus.funct3    = f3;
        bus.MemRead   = mread;
        bus.MemWrite  = mwrite;
        bus.RegWrite  = rwrite;
        bus.rd        = rdest;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [63:0] observed,
        input logic [63:0] expected
    );
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue a legal memory op and ack it in its first ACCESS cycle with rdata
    task automatic quickAccess(
        input logic [63:0] alu,
        input logic [63:0] sdata,
        input logic [2:0]  f3,
        input logic        mread,
        input logic        mwrite,
        input logic [63:0] rdata
    );
        applyStimulus(1'b1, alu, sdata, f3, mread, mwrite, 1'b1, 5'd12);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Reset state
        step();
        step();
        checkOutput("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
        checkOutput("rst_wb_data", bus.wb_data, 64'd0);
        checkOutput("rst_mem_fault", 64'(bus.mem_fault), 64'd0);
        reset = 1'b0;
        step();
        checkOutput("rst_ex_ready", 64'(bus.ex_ready), 64'd1);

        // 1: back-to-back ALU ops
        applyStimulus(1'b1, 64'h1234, 64'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        checkOutput("alu_ready0", 64'(bus.ex_ready), 64'd1);
        step();
        checkOutput("alu_valid1", 64'(bus.wb_valid), 64'd1);
        checkOutput("alu_data1", bus.wb_data, 64'h1234);
        checkOutput("alu_rd1", 64'(bus.wb_rd), 64'd5);
        checkOutput("alu_rw1", 64'(bus.wb_RegWrite), 64'd1);
        checkOutput("alu_ready1", 64'(bus.ex_ready), 64'd1);
        step();
        checkOutput("alu_valid2", 64'(bus.wb_valid), 64'd1);
        checkOutput("alu_data2", bus.wb_data, 64'h1234);
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        checkOutput("alu_valid_off", 64'(bus.wb_valid), 64'd0);
        checkOutput("alu_data_hold", bus.wb_data, 64'h1234);

        // 2: lb at 0x1003, ack in the third ACCESS cycle
        applyStimulus(1'b1, 64'h1003, 64'd0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("lb_req1", 64'(bus.mem_req), 64'd1);
        checkOutput("lb_addr", bus.mem_addr, 64'h1000);
        checkOutput("lb_we", 64'(bus.mem_we), 64'd0);
        checkOutput("lb_ready", 64'(bus.ex_ready), 64'd0);
        step();
        checkOutput("lb_req2", 64'(bus.mem_req), 64'd1);
        checkOutput("lb_nowb", 64'(bus.wb_valid), 64'd0);
        step();
        checkOutput("lb_req3", 64'(bus.mem_req), 64'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h00000000_80000000;
        step();
        bus.mem_ack = 1'b0;
        checkOutput("lb_req_drop", 64'(bus.mem_req), 64'd0);
        checkOutput("lb_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("lb_data", bus.wb_data, 64'hFFFFFFFF_FFFFFF80);
        checkOutput("lb_rd", 64'(bus.wb_rd), 64'd7);
        checkOutput("lb_rw", 64'(bus.wb_RegWrite), 64'd1);
        checkOutput("lb_fault", 64'(bus.mem_fault), 64'd0);

        // lbu from the same address, same-cycle ack
        quickAccess(64'h1003, 64'd0, 3'b100, 1'b1, 1'b0, 64'h00000000_80000000);
        checkOutput("lbu_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("lbu_data", bus.wb_data, 64'h80);

        // Further extraction cases
        quickAccess(64'h5004, 64'd0, 3'b010, 1'b1, 1'b0, 64'h80000000_00000000);
        checkOutput("lw_hi_data", bus.wb_data, 64'hFFFFFFFF_80000000);
        quickAccess(64'h5002, 64'd0, 3'b101, 1'b1, 1'b0, 64'h00000000_F00D0000);
        checkOutput("lhu_data", bus.wb_data, 64'hF00D);
        quickAccess(64'h5008, 64'd0, 3'b011, 1'b1, 1'b0, 64'h01234567_89ABCDEF);
        checkOutput("ld_data", bus.wb_data, 64'h01234567_89ABCDEF);

        // 3: sh at 0x2006 with a same-cycle ack
        applyStimulus(1'b1, 64'h2006, 64'hABCD, 3'b001, 1'b0, 1'b1, 1'b1, 5'd3);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("sh_req", 64'(bus.mem_req), 64'd1);
        checkOutput("sh_we", 64'(bus.mem_we), 64'd1);
        checkOutput("sh_addr", bus.mem_addr, 64'h2000);
        checkOutput("sh_wstrb", 64'(bus.mem_wstrb), 64'hC0);
        checkOutput("sh_wdata", bus.mem_wdata, 64'hABCD0000_00000000);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checkOutput("sh_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("sh_rw", 64'(bus.wb_RegWrite), 64'd0);
        checkOutput("sh_req_drop", 64'(bus.mem_req), 64'd0);

        // sb at 0x8005 and sd at 0x8000 lane placement
        applyStimulus(1'b1, 64'h8005, 64'h11EE, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("sb_wstrb", 64'(bus.mem_wstrb), 64'h20);
        checkOutput("sb_wdata", bus.mem_wdata, 64'h0011EE00_00000000);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        applyStimulus(1'b1, 64'h8000, 64'h11223344_55667788, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("sd_wstrb", 64'(bus.mem_wstrb), 64'hFF);
        checkOutput("sd_wdata", bus.mem_wdata, 64'h11223344_55667788);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;

        // mem_ack while IDLE is ignored
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checkOutput("idle_ack_nowb", 64'(bus.wb_valid), 64'd0);
        checkOutput("idle_ack_noreq", 64'(bus.mem_req), 64'd0);

        // 4: misaligned lw at 0x3002
        applyStimulus(1'b1, 64'h3002, 64'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("lw_mis_req", 64'(bus.mem_req), 64'd0);
        checkOutput("lw_mis_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("lw_mis_fault", 64'(bus.mem_fault), 64'd1);
        checkOutput("lw_mis_rw", 64'(bus.wb_RegWrite), 64'd0);
        checkOutput("lw_mis_data", bus.wb_data, 64'h3002);
        step();
        checkOutput("fault_clear", 64'(bus.mem_fault), 64'd0);
        checkOutput("fault_valid_clear", 64'(bus.wb_valid), 64'd0);

        // Illegal encodings: store with funct3[2]=1, and read+write together
        applyStimulus(1'b1, 64'h4000, 64'd0, 3'b100, 1'b0, 1'b1, 1'b0, 5'd0);
        step();
        checkOutput("st_ill_fault", 64'(bus.mem_fault), 64'd1);
        checkOutput("st_ill_req", 64'(bus.mem_req), 64'd0);
        applyStimulus(1'b1, 64'h4000, 64'd0, 3'b011, 1'b1, 1'b1, 1'b1, 5'd4);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rw_ill_fault", 64'(bus.mem_fault), 64'd1);
        checkOutput("rw_ill_rw", 64'(bus.wb_RegWrite), 64'd0);
        step();

        // 5: reset in the second ACCESS cycle of an ld, followed by a late ack
        applyStimulus(1'b1, 64'h6000, 64'd0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd10);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rstacc_req1", 64'(bus.mem_req), 64'd1);
        step();
        reset = 1'b1;
        step();
        checkOutput("rstacc_req_drop", 64'(bus.mem_req), 64'd0);
        checkOutput("rstacc_nowb", 64'(bus.wb_valid), 64'd0);
        reset       = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checkOutput("rstacc_late_nowb", 64'(bus.wb_valid), 64'd0);
        checkOutput("rstacc_late_noreq", 64'(bus.mem_req), 64'd0);
        checkOutput("rstacc_ready", 64'(bus.ex_ready), 64'd1);

        // 6: ld with no ack
        applyStimulus(1'b1, 64'h7000, 64'd0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd11);
        step();
        applyStimulus(1'b0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("to_req1", 64'(bus.mem_req), 64'd1);
        step();
        step();
        step();
        checkOutput("to_req4", 64'(bus.mem_req), 64'd1);
        step();
`ifdef MEM_TIMEOUT_EN
        checkOutput("to_req_drop", 64'(bus.mem_req), 64'd0);
        checkOutput("to_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("to_fault", 64'(bus.mem_fault), 64'd1);
        checkOutput("to_rw", 64'(bus.wb_RegWrite), 64'd0);
        checkOutput("to_ready", 64'(bus.ex_ready), 64'd1);
`else
        step();
        step();
        checkOutput("noto_req_held", 64'(bus.mem_req), 64'd1);
        checkOutput("noto_nowb", 64'(bus.wb_valid), 64'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hCAFE;
        step();
        bus.mem_ack = 1'b0;
        checkOutput("noto_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("noto_fault", 64'(bus.mem_fault), 64'd0);
        checkOutput("noto_data", bus.wb_data, 64'hCAFE);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
